cobs_stream_decoder: RTL and testbench

- Sits between Serial_rx and the framebuffer command/write state machine in the UART framebuffer design.
- Takes raw received bytes (one-cycle strobe per byte) and strips COBS framing, with 0x00 as the frame delimiter.
- Buffers decoded bytes in a small FIFO and presents them to the consumer with a valid/busy handshake.
- Tags the first byte of each frame (sof) so the consumer resynchronises its mode state without snooping raw bytes.

---
 rtl/cobs_stream_decoder.sv | 142 ++++++++++++++
 tb/tb_cobs_stream_decoder.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cobs_stream_decoder.sv
// cobs_stream_decoder: strips COBS framing from raw received bytes into a first-word fall-through FIFO whose entries carry a start-of-frame tag.
module cobs_stream_decoder #(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    input  logic               out_busy,
    output logic               out_valid,
    output logic [7:0]         out_data,
    output logic               out_sof,
    output logic               frame_done,
    output logic               frame_err,
    output logic [FIFO_AW:0]   fifo_level
);
    typedef enum logic [1:0] {HUNT, IDLE, DATA, CODE} state_t;
    localparam logic [FIFO_AW:0] LP_FULL = FIFO_DEPTH[FIFO_AW:0];

    state_t             r_state, w_state;
    logic [7:0]         r_remaining, w_remaining;
    logic               r_block_max, w_block_max;
    logic               r_pending_zero, w_pending_zero;
    logic               r_first, w_first;
    logic               r_done, w_done;
    logic               r_err, w_err;
    logic [8:0]         r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] r_wptr, r_rptr;
    logic [FIFO_AW:0]   r_level;
    logic               w_zero, w_pop, w_room, w_push_req, w_push, w_load;
    logic [8:0]         w_push_entry;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= HUNT;
            r_remaining    <= '0;
            r_block_max    <= 1'b0;
            r_pending_zero <= 1'b0;
            r_first        <= 1'b1;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_level        <= '0;
        end else begin
            r_state        <= w_state;
            r_remaining    <= w_remaining;
            r_block_max    <= w_block_max;
            r_pending_zero <= w_pending_zero;
            r_first        <= w_first;
            r_done         <= w_done;
            r_err          <= w_err;
            r_wptr         <= r_wptr + {{(FIFO_AW-1){1'b0}}, w_push};
            r_rptr         <= r_rptr + {{(FIFO_AW-1){1'b0}}, w_pop};
            r_level        <= r_level + {{FIFO_AW{1'b0}}, w_push} - {{FIFO_AW{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= w_push_entry;
    end

    // A full FIFO still accepts a byte when the head leaves in the same cycle
    always_comb begin
        w_zero         = in_data == 8'h00;
        w_pop          = (r_level != '0) && !out_busy;
        w_room         = (r_level != LP_FULL) || w_pop;
        w_state        = r_state;
        w_remaining    = r_remaining;
        w_block_max    = r_block_max;
        w_pending_zero = r_pending_zero;
        w_first        = r_first;
        w_done         = 1'b0;
        w_err          = 1'b0;
        w_load         = 1'b0;
        w_push_req     = 1'b0;
        w_push_entry   = {r_first, in_data};
        if (in_valid) begin
            case (r_state)
                HUNT: if (w_zero) begin
                    w_state = IDLE;
                    w_first = 1'b1;
                end
                IDLE: w_load = !w_zero;
                DATA: if (w_zero) begin
                    w_err   = 1'b1;
                    w_state = IDLE;
                    w_first = 1'b1;
                end else begin
                    w_push_req = 1'b1;
                    if (w_room) begin
                        w_first     = 1'b0;
                        w_remaining = r_remaining - 8'd1;
                        if (r_remaining == 8'd1) begin
                            w_state        = CODE;
                            w_pending_zero = !r_block_max;
                        end
                    end else begin
                        w_err          = 1'b1;
                        w_state        = HUNT;
                        w_pending_zero = 1'b0;
                    end
                end
                CODE: if (w_zero) begin
                    w_done  = 1'b1;
                    w_state = IDLE;
                    w_first = 1'b1;
                end else begin
                    w_push_req   = r_pending_zero;
                    w_push_entry = {r_first, 8'h00};
                    if (r_pending_zero && !w_room) begin
                        w_err          = 1'b1;
                        w_state        = HUNT;
                        w_pending_zero = 1'b0;
                    end else begin
                        w_load  = 1'b1;
                        w_first = r_pending_zero ? 1'b0 : r_first;
                    end
                end
                default: w_state = HUNT;
            endcase
        end
        // A code of 1 carries no data, so its block is already complete on load
        if (w_load) begin
            w_remaining    = in_data - 8'd1;
            w_block_max    = in_data == 8'hFF;
            w_pending_zero = in_data == 8'h01;
            w_state        = (in_data == 8'h01) ? CODE : DATA;
        end
        w_push = w_push_req && w_room;
    end

    always_comb begin
        out_valid           = r_level != '0;
        {out_sof, out_data} = out_valid ? r_mem[r_rptr] : 9'd0;
        frame_done          = r_done;
        frame_err           = r_err;
        fifo_level          = r_level;
    end
endmodule

// File: tb/tb_cobs_stream_decoder.sv
// tb_cobs_stream_decoder: vector table, hand-written corner sequences and randomized COBS streams checked against a frame-level decode model.
module tb_cobs_stream_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_busy = 1'b0;
    logic       out_valid, out_sof, frame_done, frame_err;
    logic [7:0] out_data;
    logic [4:0] fifo_level;

    int n_cmp = 0;
    int n_bad = 0;
    logic [8:0] q_got[$];
    logic [8:0] q_exp[$];
    logic [7:0] q_raw[$];
    logic [7:0] q_seg[$];
    int got_done = 0, got_err = 0, got_both = 0;
    int base_q, base_done, base_err, base_both;
    int exp_done, exp_err;

    typedef struct {
        logic [127:0] raw;
        int           nraw;
        logic [63:0]  dat;
        int           ndat;
        logic [7:0]   sof;
        int           done;
        int           err;
    } vec_t;
    vec_t vecs[8];

    cobs_stream_decoder #(.FIFO_DEPTH(16), .FIFO_AW(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .out_busy(out_busy),
        .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof),
        .frame_done(frame_done), .frame_err(frame_err), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst) begin
            if (out_valid && !out_busy) q_got.push_back({out_sof, out_data});
            if (frame_done) got_done++;
            if (frame_err) got_err++;
            if (frame_done && frame_err) got_both++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic mark();
        base_q    = q_got.size();
        base_done = got_done;
        base_err  = got_err;
        base_both = got_both;
    endtask

    task automatic drain();
        int t;
        t = 0;
        out_busy = 1'b0;
        while (fifo_level != 0 && t < 300) begin
            tick();
            t++;
        end
        if (t == 300) chk("drain_timeout", int'(fifo_level), 0);
        tick();
        tick();
    endtask

    task automatic check_result(input string name);
        int n;
        n = q_got.size() - base_q;
        chk({name, "_count"}, n, q_exp.size());
        for (int i = 0; i < q_exp.size() && i < n; i++)
            chk($sformatf("%s_out%0d", name, i), int'(q_got[base_q + i]), int'(q_exp[i]));
        chk({name, "_done"}, got_done - base_done, exp_done);
        chk({name, "_err"}, got_err - base_err, exp_err);
        chk({name, "_both"}, got_both - base_both, 0);
    endtask

    // Decode one delimiter-bounded segment by COBS block arithmetic
    task automatic decode_seg();
        int n, i, c;
        bit first, trunc;
        n = q_seg.size();
        i = 0;
        first = 1'b1;
        trunc = 1'b0;
        if (n == 0) return;
        while (i < n && !trunc) begin
            c = int'(q_seg[i]);
            for (int j = i + 1; j < i + c && j < n; j++) begin
                q_exp.push_back({first, q_seg[j]});
                first = 1'b0;
            end
            if (i + c > n) trunc = 1'b1;
            else begin
                i += c;
                if (i < n && c != 255) begin
                    q_exp.push_back({first, 8'h00});
                    first = 1'b0;
                end
            end
        end
        if (trunc) exp_err++;
        else exp_done++;
    endtask

    task automatic model_decode();
        bit hunting;
        hunting = 1'b1;
        q_exp.delete();
        q_seg.delete();
        exp_done = 0;
        exp_err  = 0;
        foreach (q_raw[k]) begin
            if (q_raw[k] != 8'h00) begin
                if (!hunting) q_seg.push_back(q_raw[k]);
            end else begin
                if (!hunting) decode_seg();
                hunting = 1'b0;
                q_seg.delete();
            end
        end
    endtask

    task automatic enc_frame(input int len, input bit trunc);
        logic [7:0] blk[$];
        logic [7:0] enc[$];
        logic [7:0] b;
        for (int k = 0; k < len; k++) begin
            b = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom_range(255, 1));
            if (b == 8'h00) begin
                enc.push_back(8'(blk.size() + 1));
                foreach (blk[m]) enc.push_back(blk[m]);
                blk.delete();
            end else blk.push_back(b);
        end
        enc.push_back(8'(blk.size() + 1));
        foreach (blk[m]) enc.push_back(blk[m]);
        if (trunc && enc.size() > 1)
            repeat ($urandom_range(enc.size() - 1, 1)) void'(enc.pop_back());
        foreach (enc[m]) q_raw.push_back(enc[m]);
        q_raw.push_back(8'h00);
    endtask

    task automatic exp_run(input logic [7:0] first_val, input int cnt);
        for (int k = 0; k < cnt; k++) q_exp.push_back({k == 0, 8'(first_val + k)});
    endtask

    initial begin
        vec_t cv;
        vecs[0] = '{128'h00031122023300,     7, 64'h11220033,   4, 8'b00001, 1, 0};
        vecs[1] = '{128'h0005AABB0002CC00,   8, 64'hAABBCC,     3, 8'b00101, 1, 1};
        vecs[2] = '{128'h12340002B100,       6, 64'hB1,         1, 8'b00001, 1, 0};
        vecs[3] = '{128'h000100,             3, 64'h0,          0, 8'b00000, 1, 0};
        vecs[4] = '{128'h00010100,           4, 64'h00,         1, 8'b00001, 1, 0};
        vecs[5] = '{128'h0000024100,         5, 64'h41,         1, 8'b00001, 1, 0};
        vecs[6] = '{128'h00031100,           4, 64'h11,         1, 8'b00001, 0, 1};
        vecs[7] = '{128'h0002AA03BBCC0100,   8, 64'hAA00BBCC00, 5, 8'b00001, 1, 0};

        tick();
        tick();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sof", int'(out_sof), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_fifo_level", int'(fifo_level), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        rst = 1'b1;

        for (int v = 0; v < 8; v++) begin
            cv = vecs[v];
            do_reset();
            mark();
            for (int i = 0; i < cv.nraw; i++) send(cv.raw[8*(cv.nraw-1-i) +: 8]);
            drain();
            q_exp.delete();
            for (int i = 0; i < cv.ndat; i++) q_exp.push_back({cv.sof[i], cv.dat[8*(cv.ndat-1-i) +: 8]});
            exp_done = cv.done;
            exp_err  = cv.err;
            check_result($sformatf("vec%0d", v));
        end

        do_reset();
        mark();
        send(8'h00);
        send(8'hFF);
        for (int k = 1; k <= 254; k++) send(8'(k));
        send(8'h00);
        drain();
        q_exp.delete();
        exp_run(8'h01, 254);
        exp_done = 1;
        exp_err  = 0;
        check_result("max");
        mark();
        send(8'hFF);
        for (int k = 1; k <= 254; k++) send(8'(k));
        send(8'h02);
        send(8'hAA);
        send(8'h00);
        drain();
        q_exp.push_back({1'b0, 8'hAA});
        check_result("max_cont");

        do_reset();
        mark();
        out_busy = 1'b1;
        send(8'h00);
        send(8'hFF);
        for (int k = 0; k < 16; k++) send(8'(8'h21 + k));
        chk("ovf_level16", int'(fifo_level), 16);
        send(8'h31);
        chk("ovf_err_pulse", int'(frame_err), 1);
        chk("ovf_level_hold", int'(fifo_level), 16);
        send(8'h32);
        send(8'h33);
        send(8'h34);
        send(8'h00);
        drain();
        q_exp.delete();
        exp_run(8'h21, 16);
        exp_done = 0;
        exp_err  = 1;
        check_result("ovf");
        mark();
        send(8'h02);
        send(8'hCC);
        send(8'h00);
        drain();
        q_exp.delete();
        q_exp.push_back({1'b1, 8'hCC});
        exp_done = 1;
        exp_err  = 0;
        check_result("ovf_after");

        do_reset();
        send(8'h12);
        send(8'h34);
        tick();
        chk("hunt_level", int'(fifo_level), 0);
        out_busy = 1'b1;
        send(8'h00);
        send(8'h04);
        send(8'hA1);
        send(8'hA2);
        chk("mid_level2", int'(fifo_level), 2);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mid_rst_level", int'(fifo_level), 0);
        chk("mid_rst_valid", int'(out_valid), 0);
        mark();
        send(8'hA3);
        send(8'h00);
        send(8'h02);
        send(8'hB1);
        send(8'h00);
        drain();
        q_exp.delete();
        q_exp.push_back({1'b1, 8'hB1});
        exp_done = 1;
        exp_err  = 0;
        check_result("mid_after");

        do_reset();
        mark();
        out_busy = 1'b1;
        send(8'h00);
        send(8'hFF);
        for (int k = 0; k < 16; k++) send(8'(8'h41 + k));
        chk("full_level", int'(fifo_level), 16);
        out_busy = 1'b0;
        send(8'h51);
        out_busy = 1'b1;
        chk("sim_level", int'(fifo_level), 16);
        chk("sim_err", int'(frame_err), 0);
        drain();
        q_exp.delete();
        exp_run(8'h41, 17);
        exp_done = 0;
        exp_err  = 0;
        check_result("sim");

        for (int r = 0; r < 3; r++) begin
            do_reset();
            mark();
            q_raw.delete();
            q_raw.push_back(8'($urandom_range(255, 1)));
            q_raw.push_back(8'($urandom_range(255, 1)));
            q_raw.push_back(8'h00);
            for (int f = 0; f < 12; f++) begin
                enc_frame($urandom_range(30, 0), $urandom_range(3) == 0);
                if ($urandom_range(5) == 0) q_raw.push_back(8'h00);
            end
            model_decode();
            foreach (q_raw[k]) begin
                out_busy = (fifo_level < 12) && ($urandom_range(3) == 0);
                send(q_raw[k]);
                out_busy = (fifo_level < 12) && ($urandom_range(3) == 0);
                tick();
            end
            drain();
            check_result($sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
